array_mult_sequencer: RTL and testbench
=======================================

# array_mult_sequencer

Iterative unsigned multiplier controller. It drives one WIDTH-bit array-cell row per clock and produces a 2·WIDTH-bit product after WIDTH row passes. It sits directly upstream of the oscillator's multiplier row: it feeds the row with operand a, the current multiplier bit, the running column sums and carry-in, then captures the row's sum/carry. It replaces a fully unrolled array with a time-multiplexed one for amplitude and phase scaling.

## Interface

- WIDTH, 4, operand width in bits; product is 2·WIDTH bits; legal range 2..16.

- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high; returns the block to IDLE immediately.
- start  input  1  request; sampled each rising edge, accepted only in IDLE or DONE.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high while a multiplication is in progress (RUN state).
- done  output  1  one-cycle pulse; product valid this cycle.
- product  output  2·WIDTH  result; held until the next accepted start.

## Operation

- States: IDLE, RUN, DONE. Encoding is free; state must be registered.
- IDLE: if start=1 at the edge, capture a→a_reg, b→lo (WIDTH bits), clear hi (WIDTH bits), clear count, and go to RUN. Otherwise stay.
- RUN, once per edge:
  - Row input: partial = a_reg AND {WIDTH{lo[0]}}.
  - Row add: {c, s} = hi + partial, giving a (WIDTH+1)-bit ripple sum with carry-in 0.
  - Shift right: hi ← {c, s[WIDTH-1:1]}, lo ← {s[0], lo[WIDTH-1:1]}.
  - count ← count+1.
  - When count = WIDTH−1 (the final row), go to DONE and load product ← next {hi, lo}.
- DONE: lasts exactly one cycle. start=1 is accepted exactly as in IDLE, so the next edge goes to RUN with new operands. Otherwise go to IDLE.
- start in RUN is ignored, not queued. Operand changes in RUN have no effect.
- Arithmetic is unsigned, with no overflow possible: (2^W−1)² < 2^(2W).
- count width is clog2(WIDTH)+1. No wrap occurs because the exit is at WIDTH−1.
- product does not change in RUN. It updates only on the edge that enters DONE.

## Timing

- Reset values: state=IDLE, busy=0, done=0, product=0, internal registers 0.
- Reset asserted mid-RUN aborts the operation. No done is issued and product returns to 0.
- busy=1 in RUN only. done=1 in DONE only. busy and done are never high together.
- Latency: start accepted at edge E0, busy high from E0 through E0+WIDTH−1, done and valid product for the cycle after edge E0+WIDTH.
  - WIDTH=4: 4 clocks from accept to done.
- Throughput: back-to-back with start held high gives one result per WIDTH+1 clocks.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- WIDTH=4, a=15, b=15, one-cycle start → done exactly 4 edges after accept, product=225, busy high for 4 cycles.
- a=9, b=6 → product=54. Then a=0, b=13 → product=0. Then a=1, b=1 → product=1. Each done is a single-cycle pulse.
- Start re-pulsed during RUN with a=3, b=3 → ignored. The in-flight 9×6 still returns 54 and only one done is seen.
- Reset asserted asynchronously mid-edge during RUN (count=2) → busy, done and product are 0 immediately. A following start with 7×7 returns 49.
- start held high continuously with operands changing per result → results every 5 clocks, each matching the operands captured at its accepting edge (DONE→RUN with no IDLE gap).
- Exhaustive sweep of all 256 operand pairs at WIDTH=4, plus random 10k pairs at WIDTH=8 → product equals a·b every time, with no missing or extra done pulses.

Source files
------------

// File: rtl/array_mult_sequencer_if.sv
// Operand/result bundle for the time-multiplexed multiplier sequencer.
// Signal directions are named from the sequencer's point of view.
interface array_mult_sequencer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic                 i_start;
  logic [WIDTH-1:0]     i_a;
  logic [WIDTH-1:0]     i_b;
  logic                 o_busy;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_product;

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/array_mult_sequencer.sv
// Iterative unsigned shift-add multiplier: one WIDTH-bit array row per clock,
// 2*WIDTH-bit product after WIDTH row passes.
module array_mult_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input logic                    i_clock,
  input logic                    i_reset,
  array_mult_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastRow = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_partial;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_hi_nxt;
  logic [WIDTH-1:0]     w_lo_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_count == LastRow);
    case (r_state)
      // DONE behaves like IDLE for a new request, otherwise falls back to IDLE.
      StIdle, StDone: begin
        w_state_nxt = StIdle;
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_last) w_state_nxt = StDone;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // One array row: gate a by the current multiplier bit, add into the high half.
  always_comb begin
    w_partial = r_a & {WIDTH{r_lo[0]}};
    w_sum     = {1'b0, r_hi} + {1'b0, w_partial};
    w_hi_nxt  = w_sum[WIDTH:1];
    w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a     <= bus.i_a;
      r_lo    <= bus.i_b;
      r_hi    <= '0;
      r_count <= '0;
    end else if (r_state == StRun) begin
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= r_count + CW'(1);
      if (w_last) r_product <= {w_hi_nxt, w_lo_nxt};
    end
  end

  assign bus.o_busy    = (r_state == StRun);
  assign bus.o_done    = (r_state == StDone);
  assign bus.o_product = r_product;

endmodule

// File: tb/tb_array_mult_sequencer.sv
// Randomised scoreboard bench for array_mult_sequencer with a cycle-level
// acceptance model and a plain a*b reference.
module tb_array_mult_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  logic rst;

  array_mult_sequencer_if #(.WIDTH(W)) bus ();

  array_mult_sequencer #(.WIDTH(W)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [PW-1:0] exp_q[$];
  int            m_left;
  logic          m_done;
  logic [PW-1:0] m_prod;
  logic [PW-1:0] m_pending;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted request occupies W cycles, then its result is
  // shown for one cycle, during which a new request may be accepted.
  initial begin
    m_left    = 0;
    m_done    = 1'b0;
    m_prod    = '0;
    m_pending = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_left = 0;
        m_done = 1'b0;
        m_prod = '0;
        exp_q.delete();
      end else if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
        if (m_done) m_prod = m_pending;
      end else begin
        m_done = 1'b0;
        if (bus.i_start) begin
          m_left    = W;
          m_pending = PW'(bus.i_a) * PW'(bus.i_b);
          exp_q.push_back(m_pending);
        end
      end
    end
  end

  // Monitor: per-cycle status checks plus scoreboard pop on each done.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        check("busy", 64'(bus.o_busy), 64'(m_left > 0));
        check("done", 64'(bus.o_done), 64'(m_done));
        check("product_hold", 64'(bus.o_product), 64'(m_prod));
        if (bus.o_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_extra_done: got done with 0 pending, expected 1 pending at t=%0t",
                     $time);
          end else begin
            check("sb_product", 64'(bus.o_product), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.i_start = s;
    bus.i_a     = a;
    bus.i_b     = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, W'($urandom), W'($urandom));
  endtask

  // One-cycle start then W scrambled idle cycles; the next op lands in DONE.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, a, b);
    idle(W);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.o_busy), 64'(0));
    check("reset_done", 64'(bus.o_done), 64'(0));
    check("reset_product", 64'(bus.o_product), 64'(0));
    rst = 1'b0;

    op(4'(15), 4'(15));
    idle(2);
    op(4'(9), 4'(6));
    op(4'(0), 4'(13));
    op(4'(1), 4'(1));
    idle(2);

    // Start re-pulsed mid-run must be ignored.
    drive(1'b1, 4'(9), 4'(6));
    drive(1'b0, 4'(0), 4'(0));
    drive(1'b1, 4'(3), 4'(3));
    idle(W + 1);

    // Asynchronous reset two rows into an operation.
    drive(1'b1, 4'(11), 4'(13));
    drive(1'b0, 4'(0), 4'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", 64'(bus.o_busy), 64'(0));
    check("midrun_rst_done", 64'(bus.o_done), 64'(0));
    check("midrun_rst_product", 64'(bus.o_product), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    op(4'(7), 4'(7));
    idle(2);

    // Start held high: back-to-back results, operands changing every cycle.
    for (int k = 0; k < 6 * (W + 1); k++) drive(1'b1, W'($urandom), W'($urandom));
    idle(W + 2);

    for (int i = 0; i < (1 << (2 * W)) && i < 4096; i++) op(i[W-1:0], i[2*W-1:W]);
    idle(2);

    for (int k = 0; k < 1500; k++)
      drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));

    idle(W + 3);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
